capture_packer: RTL
===================

CAPTURE_PACKER -- requirements
Module: capture_packer

Interface
REQ-001 SHALL have parameter OUT_W, default 256, meaning output word width in bits (power of two).
REQ-002 SHALL have parameter IN_W, default 32, meaning maximum sample width in bits (power of two, at most OUT_W).
REQ-003 SHALL have parameter POS_W, default 3, meaning sub-sample trigger position width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port width_sel, input, $clog2(IN_W)+1, meaning sample width = 2^width_sel bits; values above log2(IN_W) are invalid.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data holds a sample this cycle.
REQ-008 SHALL have port in_data, input, IN_W, meaning sample; only the low 2^width_sel bits are used.
REQ-009 SHALL have port trig_valid, input, 1, meaning trigger hit in the current sample; qualified by in_valid.
REQ-010 SHALL have port trig_pos, input, POS_W, meaning sub-sample trigger position.
REQ-011 SHALL have port flush, input, 1, meaning close the current word (end of capture).
REQ-012 SHALL have port ovf_clr, input, 1, meaning clear the sticky overflow flag.
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1), meaning a valid/ready word handshake.
REQ-014 SHALL have port out_data, output, OUT_W, meaning the packed word.
REQ-015 SHALL have port out_count, output, $clog2(OUT_W)+1, meaning the number of valid samples in the word.
REQ-016 SHALL have ports out_last (output, 1) and out_trig (output, 1), meaning flush-terminated word and word-contains-trigger.
REQ-017 SHALL have port out_trig_idx, output, $clog2(OUT_W)+POS_W, meaning {sample index within word, trig_pos}.
REQ-018 SHALL have port overflow, output, 1, meaning sticky: a completed word was dropped.

Function
REQ-019 SHALL latch width_sel into an active-width register only when the accumulated sample count is 0; mid-word changes are ignored until the next word.
REQ-020 SHALL, per accepted sample, shift the accumulator left by 2^w and insert the sample in the LSBs; N = OUT_W/2^w samples complete a word.
REQ-021 SHALL push a completed word (count N) into the output buffer in the same cycle as its last sample; out_valid rises the next cycle (1-cycle latency).
REQ-022 SHALL, on the first trig_valid&in_valid of a word, record idx = {samples already in word, trig_pos} and set the word's trig flag; later triggers in the same word are ignored.
REQ-023 SHALL, on flush, zero-pad the remaining slots (shift left by (N-count)*2^w) and push a word with out_last=1 and out_count=count, including count=0 (all-zero word).
REQ-024 SHALL, when in_valid and flush coincide, include the sample first; if that sample completes the word, push exactly one word with out_last=1.
REQ-025 SHALL, when a word completes while the buffer is full, drop that word, set overflow, and restart accumulation at count 0 with no stall.
REQ-026 SHALL clear overflow on ovf_clr unless a drop occurs in the same cycle, in which case overflow stays set.
REQ-027 SHALL pop the buffer on out_valid&out_ready; a push and pop in the same cycle on a full buffer SHALL succeed (no overflow).
REQ-028 SHALL hold out_data, out_count, out_last, out_trig and out_trig_idx stable while out_valid&!out_ready.

Reset
REQ-029 SHALL, on rst, clear the accumulator, sample count, trig flag, buffer, overflow and active width; out_valid=0 and all other outputs read 0 on the next cycle.
REQ-030 SHALL, on reset mid-word, discard the partial word without emitting it.

Structure
REQ-031 SHALL place the word-sideband struct (count, last, trig, trig_idx) and the samples-per-word function in the shared package capture_pkg.
REQ-032 SHALL implement the output buffer as sub-module capture_out_fifo, 2 entries deep, with data and sideband stored together.

Verification
REQ-033 SHALL cover w=5, 8 samples 0..7, out_ready=1 -> one word {0,...,7} with 7 in the LSBs, count=8, last=0, trig=0.
REQ-034 SHALL cover w=0, trigger on sample 10 with trig_pos=5 -> out_trig=1, out_trig_idx={10,3'd5}; a second trigger in the same word leaves the index unchanged.
REQ-035 SHALL cover w=3, 5 samples then flush -> count=5, last=1, the 5 samples in the upper 40 bits, lower 216 bits zero.
REQ-036 SHALL cover w=5, out_ready=0 for 24 samples -> 2 words held, third dropped, overflow=1; ovf_clr -> overflow=0.
REQ-037 SHALL cover a width_sel change 3->5 mid-word -> the current word finishes at 8-bit width and the next word uses 32-bit width.
REQ-038 SHALL cover rst asserted after 3 samples -> out_valid=0 next cycle and the next 8 32-bit samples form a clean word.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture packer: the per-word sideband
// record that travels with each packed word, and the samples-per-word helper.
package capture_pkg;

  // Sideband fields are sized generously so any OUT_W up to 32768 and
  // POS_W up to 8 fit. The packer slices out the bits it actually uses.
  localparam int SB_CNT_W = 16;
  localparam int SB_IDX_W = 24;

  typedef struct packed {
    logic [SB_CNT_W-1:0] count;
    logic                last;
    logic                trig;
    logic [SB_IDX_W-1:0] trig_idx;
  } word_sb_t;

  localparam int SB_W = $bits(word_sb_t);

  // Number of 2^width_log2-bit samples that fill one out_w-bit word.
  function automatic int unsigned samples_per_word(input int unsigned out_w,
                                                   input int unsigned width_log2);
    return out_w >> width_log2;
  endfunction

endpackage

// File: rtl/capture_out_fifo.sv
// Two-entry output buffer for packed words. Each entry stores the word data
// and its sideband together so they can never drift apart. A push into a
// full buffer is accepted when a pop happens in the same cycle. Head outputs
// read zero whenever the buffer is empty.
module capture_out_fifo import capture_pkg::*; #(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  word_sb_t          push_sb,
  input  logic              pop,
  output logic              not_empty,
  output logic              full,
  output logic [DATA_W-1:0] head_data,
  output word_sb_t          head_sb
);

  localparam int ENTRY_W = DATA_W + SB_W;

  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               push_ok;
  logic               pop_ok;
  logic [ENTRY_W-1:0] head_entry;

  // Work out which pushes and pops take effect and the resulting pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pop_ok   = pop && (cnt_q != 2'd0);
    push_ok  = push && ((cnt_q != 2'd2) || pop_ok);

    if (push_ok) begin
      mem_d[wr_ptr_q] = {push_sb, push_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Buffer storage and pointers; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Present the oldest entry, forced to zero while the buffer is empty.
  always_comb begin
    not_empty  = (cnt_q != 2'd0);
    full       = (cnt_q == 2'd2);
    head_entry = mem_q[rd_ptr_q];
    head_data  = '0;
    head_sb    = '0;
    if (not_empty) begin
      head_data = head_entry[DATA_W-1:0];
      head_sb   = head_entry[ENTRY_W-1:DATA_W];
    end
  end

endmodule

// File: rtl/capture_packer.sv
// Capture packer: accumulates variable-width samples into OUT_W-bit words,
// oldest sample in the MSBs, records the first trigger position per word,
// zero-pads words closed early by flush, and hands finished words to a
// two-entry buffer with a valid/ready interface. A word that completes while
// the buffer is full is dropped and flagged in a sticky overflow bit.
module capture_packer import capture_pkg::*; #(
  parameter int OUT_W = 256,
  parameter int IN_W  = 32,
  parameter int POS_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(IN_W):0]         width_sel,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          trig_valid,
  input  logic [POS_W-1:0]              trig_pos,
  input  logic                          flush,
  input  logic                          ovf_clr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [$clog2(OUT_W):0]        out_count,
  output logic                          out_last,
  output logic                          out_trig,
  output logic [$clog2(OUT_W)+POS_W-1:0] out_trig_idx,
  output logic                          overflow
);

  localparam int WSEL_W  = $clog2(IN_W) + 1;
  localparam int MAX_LOG = $clog2(IN_W);
  localparam int CNT_W   = $clog2(OUT_W) + 1;
  localparam int IDX_W   = $clog2(OUT_W) + POS_W;

  // Word-in-progress state.
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WSEL_W-1:0] w_q, w_d;
  logic              trig_q, trig_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ovf_q, ovf_d;

  // Datapath intermediates.
  logic [WSEL_W-1:0] sel_clamped;
  logic [WSEL_W-1:0] eff_w;
  logic [CNT_W-1:0]  samp_bits;
  logic [CNT_W-1:0]  n_samples;
  logic [IN_W-1:0]   in_mask;
  logic [OUT_W-1:0]  sample_ext;
  logic [OUT_W-1:0]  acc_new;
  logic [CNT_W-1:0]  cnt_new;
  logic              trig_new;
  logic [IDX_W-1:0]  idx_new;
  logic              complete;
  logic [CNT_W-1:0]  pad_bits;

  // Buffer interface.
  logic              push;
  logic [OUT_W-1:0]  push_data;
  word_sb_t          push_sb;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_not_empty;
  logic [OUT_W-1:0]  head_data;
  word_sb_t          head_sb;
  logic              sb_unused;

  // Pick the active width, fold in this cycle's sample and trigger, and
  // decide whether a word leaves the accumulator (full word or flush).
  always_comb begin
    // Out-of-range selections are treated as the widest legal sample.
    sel_clamped = (width_sel > WSEL_W'(MAX_LOG)) ? WSEL_W'(MAX_LOG) : width_sel;
    // A new width only takes hold at a word boundary.
    eff_w       = (cnt_q == '0) ? sel_clamped : w_q;
    w_d         = eff_w;

    samp_bits   = CNT_W'(1) << eff_w;
    n_samples   = CNT_W'(samples_per_word(OUT_W, 32'(eff_w)));
    in_mask     = ~({IN_W{1'b1}} << samp_bits);
    sample_ext  = OUT_W'(in_data & in_mask);

    acc_new     = acc_q;
    cnt_new     = cnt_q;
    if (in_valid) begin
      acc_new = (acc_q << samp_bits) | sample_ext;
      cnt_new = cnt_q + CNT_W'(1);
    end
    complete    = in_valid && (cnt_new == n_samples);

    // Only the first trigger of a word is recorded; its index is the number
    // of samples already in the word, concatenated with the sub-sample pos.
    trig_new    = trig_q;
    idx_new     = idx_q;
    if (in_valid && trig_valid && !trig_q) begin
      trig_new = 1'b1;
      idx_new  = {cnt_q[CNT_W-2:0], trig_pos};
    end

    // Left-justify a partial word so unfilled slots become trailing zeros.
    pad_bits    = (n_samples - cnt_new) << eff_w;

    push             = complete || flush;
    push_data        = acc_new << pad_bits;
    push_sb          = '0;
    push_sb.count    = SB_CNT_W'(cnt_new);
    push_sb.last     = flush;
    push_sb.trig     = trig_new;
    push_sb.trig_idx = SB_IDX_W'(idx_new);

    pop  = fifo_not_empty && out_ready;
    drop = push && fifo_full && !pop;

    // Whether accepted or dropped, a pushed word frees the accumulator.
    if (push) begin
      acc_d  = '0;
      cnt_d  = '0;
      trig_d = 1'b0;
      idx_d  = '0;
    end else begin
      acc_d  = acc_new;
      cnt_d  = cnt_new;
      trig_d = trig_new;
      idx_d  = idx_new;
    end

    // A drop in the same cycle as a clear request wins.
    ovf_d = drop || (ovf_q && !ovf_clr);
  end

  // Accumulator, counters, width latch and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      w_q    <= '0;
      trig_q <= 1'b0;
      idx_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      w_q    <= w_d;
      trig_q <= trig_d;
      idx_q  <= idx_d;
      ovf_q  <= ovf_d;
    end
  end

  capture_out_fifo #(
    .DATA_W (OUT_W)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .push_sb   (push_sb),
    .pop       (pop),
    .not_empty (fifo_not_empty),
    .full      (fifo_full),
    .head_data (head_data),
    .head_sb   (head_sb)
  );

  // Unpack the buffer head onto the output ports.
  always_comb begin
    out_valid    = fifo_not_empty;
    out_data     = head_data;
    out_count    = head_sb.count[CNT_W-1:0];
    out_last     = head_sb.last;
    out_trig     = head_sb.trig;
    out_trig_idx = head_sb.trig_idx[IDX_W-1:0];
    overflow     = ovf_q;
    sb_unused    = ^{head_sb.count[SB_CNT_W-1:CNT_W], head_sb.trig_idx[SB_IDX_W-1:IDX_W]};
  end

endmodule
